dmem_result_scanner: RTL and testbench



---
 rtl/dmem_result_scanner_pkg.sv | 29 ++
 rtl/dmem_result_scanner_if.sv | 33 +++
 rtl/dmem_result_scanner.sv | 124 ++++++++++++
 tb/tb_dmem_result_scanner.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_result_scanner_pkg.sv
// dmem_result_scanner_pkg: FSM state encoding and result-region geometry
// shared between the CPU data-memory sizing and the result scanner.
package dmem_result_scanner_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_OUT,
        S_FIN
    } state_t;

    // Results follow operand A (m x n) and operand B (n x n2) in memory.
    function automatic int unsigned calc_base(
        input int unsigned m,
        input int unsigned n,
        input int unsigned n2
    );
        return m * n + n * n2;
    endfunction

    function automatic int unsigned calc_count(
        input int unsigned m,
        input int unsigned n2
    );
        return m * n2;
    endfunction

endpackage

// File: rtl/dmem_result_scanner_if.sv
// dmem_result_scanner_if: data-memory read port plus result stream.
// master = scanner (drives index/result), slave = memory + consumer.
interface dmem_result_scanner_if;

    logic [31:0] mem_index;
    logic [31:0] mem_rd_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [31:0] res_index;
    logic        res_last;

    modport master (
        output mem_index,
        input  mem_rd_data,
        output res_valid,
        input  res_ready,
        output res_data,
        output res_index,
        output res_last
    );

    modport slave (
        input  mem_index,
        output mem_rd_data,
        input  res_valid,
        output res_ready,
        input  res_data,
        input  res_index,
        input  res_last
    );

endinterface

// File: rtl/dmem_result_scanner.sv
// dmem_result_scanner: on a rising cpu_done, reads the result region of data
// memory word by word, streams it out (valid/ready) and sums accepted words.
// Ports: CLOCK_50, rst (sync, active high), cpu_done, bus (read port and
// result stream), checksum, scan_done, busy.
module dmem_result_scanner
    import dmem_result_scanner_pkg::*;
#(
    parameter int unsigned M  = 100,
    parameter int unsigned N  = 50,
    parameter int unsigned N2 = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  rst,
    input  logic                  cpu_done,
    dmem_result_scanner_if.master bus,
    output logic [31:0]           checksum,
    output logic                  scan_done,
    output logic                  busy
);

    localparam int unsigned BASE   = calc_base(M, N, N2);
    localparam int unsigned COUNT  = calc_count(M, N2);
    localparam logic [31:0] BASE_W = 32'(BASE);
    localparam logic [31:0] LAST_W = 32'(COUNT) - 32'd1;
    localparam bit          EMPTY  = (COUNT == 0);

    state_t      state;
    state_t      nxt;
    logic        done_q;
    logic [31:0] cnt;
    logic [31:0] cnt_nxt;
    logic [31:0] mem_index;
    logic        res_valid;
    logic [31:0] res_data;
    logic [31:0] res_index;
    logic        res_last;

    logic start;
    logic go;
    logic cap;
    logic hs;
    logic fin;
    logic ld_idx;

    assign start = cpu_done && !done_q;

    assign bus.mem_index = mem_index;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data;
    assign bus.res_index = res_index;
    assign bus.res_last  = res_last;

    always_ff @(posedge CLOCK_50) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:    if (start) nxt = EMPTY ? S_FIN : S_ISSUE;
            S_ISSUE:   nxt = S_CAPTURE;
            S_CAPTURE: nxt = S_OUT;
            S_OUT:     if (hs) nxt = res_last ? S_FIN : S_ISSUE;
            S_FIN:     nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    // mem_index is loaded on entry to ISSUE, so the address is presented
    // during ISSUE and the synchronous read data is there in CAPTURE.
    always_comb begin
        go      = (state == S_IDLE) && start;
        cap     = (state == S_CAPTURE);
        hs      = (state == S_OUT) && res_valid && bus.res_ready;
        fin     = (state == S_FIN);
        cnt_nxt = cnt;
        if (go)
            cnt_nxt = 32'd0;
        else if (hs && !res_last)
            cnt_nxt = cnt + 32'd1;
        ld_idx  = (go && !EMPTY) || (hs && !res_last);
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            done_q    <= 1'b1;
            cnt       <= '0;
            mem_index <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_index <= '0;
            res_last  <= 1'b0;
            checksum  <= '0;
            scan_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done_q <= cpu_done;
            cnt    <= cnt_nxt;
            if (ld_idx)
                mem_index <= BASE_W + cnt_nxt;
            if (go) begin
                checksum  <= '0;
                scan_done <= 1'b0;
                busy      <= 1'b1;
            end
            if (cap) begin
                res_data  <= bus.mem_rd_data;
                res_index <= cnt;
                res_last  <= (cnt == LAST_W);
                res_valid <= 1'b1;
            end
            if (hs) begin
                checksum  <= checksum + res_data;
                res_valid <= 1'b0;
            end
            if (fin) begin
                busy      <= 1'b0;
                scan_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_result_scanner.sv
// tb_dmem_result_scanner: directed and randomized scans of a 2x2x2 layout
// (results at words 8..11) plus an empty-region instance (N2=0).
module tb_dmem_result_scanner;

    localparam int TB_BASE  = 8;
    localparam int TB_COUNT = 4;

    typedef struct {
        logic [31:0] data;
        logic [31:0] idx;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        cpu_done;
    logic        cpu_done0;
    logic [31:0] checksum;
    logic [31:0] checksum0;
    logic        scan_done;
    logic        scan_done0;
    logic        busy;
    logic        busy0;

    logic [31:0] mem [0:15];
    beat_t       got_q [$];

    int passed = 0;
    int failed = 0;
    int total  = 0;

    dmem_result_scanner_if bus ();
    dmem_result_scanner_if bus0 ();

    dmem_result_scanner #(.M(2), .N(2), .N2(2)) dut (
        .CLOCK_50  (clk),
        .rst       (rst),
        .cpu_done  (cpu_done),
        .bus       (bus.master),
        .checksum  (checksum),
        .scan_done (scan_done),
        .busy      (busy)
    );

    dmem_result_scanner #(.M(2), .N(2), .N2(0)) dut0 (
        .CLOCK_50  (clk),
        .rst       (rst),
        .cpu_done  (cpu_done0),
        .bus       (bus0.master),
        .checksum  (checksum0),
        .scan_done (scan_done0),
        .busy      (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: one-cycle synchronous read for both instances.
    always @(posedge clk) begin
        bus.mem_rd_data  <= mem[bus.mem_index[3:0]];
        bus0.mem_rd_data <= mem[bus0.mem_index[3:0]];
    end

    // Record every accepted word; ready/valid are stable at the falling edge.
    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready)
            got_q.push_back('{bus.res_data, bus.res_index, bus.res_last});
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready high, 1: random ready, 2: stall word 1 for 5 cycles.
    task automatic run_scan(input int mode, input int exp_cycles);
        int cycles = 0;
        int stall  = 0;
        got_q.delete();
        cpu_done = 1'b1;
        do begin
            if (mode == 2 && stall == 0 && bus.res_valid &&
                bus.res_index == 32'd1)
                stall = 1;
            if (stall >= 1 && stall <= 6) begin
                chk1("bp_valid", bus.res_valid, 1'b1);
                chk("bp_data", bus.res_data, mem[TB_BASE + 1]);
                chk("bp_sum", checksum, mem[TB_BASE]);
                bus.res_ready = (stall == 6);
                stall++;
            end else if (mode == 1) begin
                bus.res_ready = ($urandom_range(0, 2) != 0);
            end else begin
                bus.res_ready = 1'b1;
            end
            tick();
            cycles++;
            if (cycles == 1) begin
                chk("start_sum", checksum, 32'd0);
                chk1("start_done", scan_done, 1'b0);
                chk1("start_busy", busy, 1'b1);
            end
        end while (!scan_done && cycles < 300);
        if (exp_cycles > 0)
            chk("latency", 32'(cycles), 32'(exp_cycles));
        cpu_done = 1'b0;
        tick();
    endtask

    // Expected stream: the result slice of memory, in order, and its sum.
    task automatic check_beats(input string tag);
        logic [31:0] sum;
        sum = 32'd0;
        chk({tag, "_n"}, 32'(got_q.size()), 32'(TB_COUNT));
        for (int i = 0; i < TB_COUNT; i++) begin
            sum = sum + mem[TB_BASE + i];
            if (i < got_q.size()) begin
                chk({tag, "_data"}, got_q[i].data, mem[TB_BASE + i]);
                chk({tag, "_idx"}, got_q[i].idx, 32'(i));
                chk1({tag, "_last"}, got_q[i].last, i == TB_COUNT - 1);
            end
        end
        chk({tag, "_sum"}, checksum, sum);
        chk1({tag, "_done"}, scan_done, 1'b1);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_valid"}, bus.res_valid, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk1({tag, "_valid"}, bus.res_valid, 1'b0);
        chk1({tag, "_last"}, bus.res_last, 1'b0);
        chk1({tag, "_done"}, scan_done, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_data"}, bus.res_data, 32'd0);
        chk({tag, "_idx"}, bus.res_index, 32'd0);
        chk({tag, "_sum"}, checksum, 32'd0);
        chk({tag, "_midx"}, bus.mem_index, 32'd0);
    endtask

    task automatic load_words();
        for (int i = 0; i < 16; i++)
            mem[i] = 32'(100 + 3 * i);
        mem[8]  = 32'd5;
        mem[9]  = 32'd6;
        mem[10] = 32'd7;
        mem[11] = 32'hFFFF_FFFF;
    endtask

    initial begin
        int  cycles;
        bit  found;
        bit  seen_v;

        load_words();
        rst            = 1'b1;
        cpu_done       = 1'b1;
        cpu_done0      = 1'b0;
        bus.res_ready  = 1'b0;
        bus0.res_ready = 1'b1;
        repeat (3) tick();
        check_zero("rst");

        // cpu_done already high out of reset must not start a scan.
        rst = 1'b0;
        repeat (5) tick();
        chk1("hi_busy", busy, 1'b0);
        chk1("hi_valid", bus.res_valid, 1'b0);
        cpu_done = 1'b0;
        tick();

        run_scan(0, 3 * TB_COUNT + 2);
        check_beats("scan1");
        chk("scan1_0x11", checksum, 32'h0000_0011);

        run_scan(0, 3 * TB_COUNT + 2);
        check_beats("rescan");

        run_scan(2, 3 * TB_COUNT + 2 + 5);
        check_beats("bp");

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < TB_COUNT; i++)
                mem[TB_BASE + i] = $urandom;
            run_scan(1, 0);
            check_beats("rnd");
        end
        load_words();

        // Abort in OUT of word 2, then rescan from scratch.
        got_q.delete();
        cpu_done      = 1'b1;
        bus.res_ready = 1'b1;
        found         = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.res_valid && bus.res_index == 32'd2) begin
                found         = 1'b1;
                bus.res_ready = 1'b0;
            end else begin
                tick();
            end
        end
        chk1("abort_reach", found, 1'b1);
        rst = 1'b1;
        tick();
        check_zero("abort");
        rst      = 1'b0;
        cpu_done = 1'b0;
        tick();
        run_scan(0, 3 * TB_COUNT + 2);
        check_beats("after_abort");
        chk("after_abort_0x11", checksum, 32'h0000_0011);

        // Empty result region.
        seen_v    = 1'b0;
        cycles    = 0;
        cpu_done0 = 1'b1;
        do begin
            tick();
            cycles++;
            if (bus0.res_valid)
                seen_v = 1'b1;
        end while (!scan_done0 && cycles < 50);
        chk("empty_latency", 32'(cycles), 32'd2);
        chk1("empty_valid", seen_v, 1'b0);
        chk("empty_sum", checksum0, 32'd0);
        chk1("empty_busy", busy0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
